// File: rtl/ariane_pkg.sv
// Shared CLIC/core interrupt definitions: level width and the request
// bundle handed from the interrupt source to the core's ID stage.
package ariane_pkg;

    localparam int unsigned IrqLevelWidth = 8;
    localparam int unsigned ClicNumSrc    = 256;
    localparam int unsigned ClicIdWidth   = $clog2(ClicNumSrc);

    // One request as seen by the core: one-hot line, its level and binary id.
    typedef struct packed {
        logic [ClicNumSrc-1:0]    onehot;
        logic [IrqLevelWidth-1:0] level;
        logic [ClicIdWidth-1:0]   id;
    } clic_irq_req_t;

endpackage

// File: rtl/clic_max_tree.sv
// Log-depth comparator tree: finds the highest level among valid inputs.
// Inputs are padded up to a power of two; on equal levels the upper half
// (which always holds the higher ids) wins, giving the higher-id tie-break.
module clic_max_tree #(
    parameter int unsigned NumIn      = 256,
    parameter int unsigned LevelWidth = 8,
    parameter int unsigned IdWidth    = 8
) (
    input  logic [NumIn-1:0]                 valid_i,
    input  logic [NumIn-1:0][LevelWidth-1:0] level_i,
    output logic                             valid_o,
    output logic [LevelWidth-1:0]            level_o,
    output logic [IdWidth-1:0]               id_o
);

    localparam int unsigned Depth   = $clog2(NumIn);
    localparam int unsigned NumLeaf = 1 << Depth;

    genvar gs, gi;
    for (gs = 0; gs <= Depth; gs++) begin : g_stage
        localparam int unsigned Width = NumLeaf >> gs;
        logic [Width-1:0]                 vld;
        logic [Width-1:0][LevelWidth-1:0] lvl;
        logic [Width-1:0][IdWidth-1:0]    id;

        if (gs == 0) begin : g_leaf
            for (gi = 0; gi < Width; gi++) begin : g_node
                if (gi < NumIn) begin : g_real
                    assign vld[gi] = valid_i[gi];
                    assign lvl[gi] = valid_i[gi] ? level_i[gi] : '0;
                    assign id[gi]  = IdWidth'(gi);
                end else begin : g_pad
                    assign vld[gi] = 1'b0;
                    assign lvl[gi] = '0;
                    assign id[gi]  = '0;
                end
            end
        end else begin : g_merge
            for (gi = 0; gi < Width; gi++) begin : g_node
                logic take_hi;
                // Upper child wins when it is valid and not lower in level.
                assign take_hi = g_stage[gs-1].vld[2*gi+1]
                               & (~g_stage[gs-1].vld[2*gi]
                                  | (g_stage[gs-1].lvl[2*gi+1] >= g_stage[gs-1].lvl[2*gi]));
                assign vld[gi] = g_stage[gs-1].vld[2*gi] | g_stage[gs-1].vld[2*gi+1];
                assign lvl[gi] = take_hi ? g_stage[gs-1].lvl[2*gi+1] : g_stage[gs-1].lvl[2*gi];
                assign id[gi]  = take_hi ? g_stage[gs-1].id[2*gi+1]  : g_stage[gs-1].id[2*gi];
            end
        end
    end

    assign valid_o = g_stage[Depth].vld[0];
    assign level_o = g_stage[Depth].lvl[0];
    assign id_o    = g_stage[Depth].id[0];

endmodule

// File: rtl/clic_irq_source.sv
// CLIC-side interrupt source: latches per-source pending state, picks the
// highest-level (then highest-id) pending source, and holds a single one-hot
// request towards the core until it is acknowledged or withdrawn.
module clic_irq_source
    import ariane_pkg::*;
#(
    parameter int unsigned NumInterruptSrc = ClicNumSrc
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic [NumInterruptSrc-1:0]                    src_i,
    input  logic [NumInterruptSrc-1:0]                    src_ie_i,
    input  logic [NumInterruptSrc-1:0]                    src_edge_i,
    input  logic [NumInterruptSrc-1:0][IrqLevelWidth-1:0] src_level_i,
    output logic [NumInterruptSrc-1:0]                    irq_o,
    output logic [IrqLevelWidth-1:0]                      irq_level_o,
    output logic [$clog2(NumInterruptSrc)-1:0]            irq_id_o,
    input  logic                                          irq_ack_i
);

    localparam int unsigned IdWidth = $clog2(NumInterruptSrc);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_e;

    state_e                      state_q, state_d;
    clic_irq_req_t               req_q, req_d;
    logic [NumInterruptSrc-1:0]  src_q;
    logic [NumInterruptSrc-1:0]  pending_q, pending_d;
    logic [NumInterruptSrc-1:0]  rise;
    logic [NumInterruptSrc-1:0]  ack_clr;
    logic                        win_valid;
    logic [IrqLevelWidth-1:0]    win_level;
    logic [IdWidth-1:0]          win_id;
    logic                        held_pend_q, held_pend_d;
    logic                        leave_req;

    assign rise    = src_i & ~src_q & src_ie_i;
    // An ack only ever clears the bit of the request actually being held.
    assign ack_clr = {NumInterruptSrc{(state_q == REQ) && irq_ack_i}} & req_q.onehot;

    genvar gi;
    for (gi = 0; gi < NumInterruptSrc; gi++) begin : g_pending
        // Edge: new rising edge beats a same-cycle ack. Level: follow the line.
        assign pending_d[gi] = src_ie_i[gi]
                             & (src_edge_i[gi] ? (rise[gi] | (pending_q[gi] & ~ack_clr[gi]))
                                               : src_i[gi]);
    end

    // Withdrawal is detected on the incoming pending value as well, so a
    // level line dropping in cycle n releases the request in cycle n+1.
    assign held_pend_q = |(pending_q & req_q.onehot);
    assign held_pend_d = |(pending_d & req_q.onehot);
    assign leave_req   = irq_ack_i | ~(held_pend_q & held_pend_d);

    clic_max_tree #(
        .NumIn      (NumInterruptSrc),
        .LevelWidth (IrqLevelWidth),
        .IdWidth    (IdWidth)
    ) u_max_tree (
        .valid_i (pending_q),
        .level_i (src_level_i),
        .valid_o (win_valid),
        .level_o (win_level),
        .id_o    (win_id)
    );

    // Sample the raw lines and latch pending state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_q     <= '0;
            pending_q <= '0;
        end else begin
            src_q     <= src_i;
            pending_q <= pending_d;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: capture any winner from IDLE; leave REQ on ack or withdrawal.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_valid) state_d = REQ;
            REQ:     if (leave_req) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request contents: frozen while held, cleared whenever no request is out.
    always_comb begin
        req_d = req_q;
        case (state_q)
            IDLE: begin
                req_d = '0;
                if (win_valid) begin
                    req_d.onehot[win_id] = 1'b1;
                    req_d.level          = win_level;
                    req_d.id             = win_id;
                end
            end
            REQ: if (leave_req) req_d = '0;
            default: req_d = '0;
        endcase
    end

    // Registered request drives the core directly.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_q <= '0;
        end else begin
            req_q <= req_d;
        end
    end

    assign irq_o       = req_q.onehot;
    assign irq_level_o = req_q.level;
    assign irq_id_o    = req_q.id;

endmodule

// File: tb/tb_clic_irq_source.sv
// Self-checking bench for clic_irq_source: directed scenarios with fixed
// expectations plus a randomized run against a cycle-level reference model.
module tb_clic_irq_source;

    localparam int N  = 256;
    localparam int IW = 8;
    localparam int OW = N + 8 + IW;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic [N-1:0]      src_i = '0;
    logic [N-1:0]      src_ie_i = '0;
    logic [N-1:0]      src_edge_i = '0;
    logic [N-1:0][7:0] src_level_i = '0;
    logic [N-1:0]      irq_o;
    logic [7:0]        irq_level_o;
    logic [IW-1:0]     irq_id_o;
    logic              irq_ack_i = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    clic_irq_source #(.NumInterruptSrc(N)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .src_i       (src_i),
        .src_ie_i    (src_ie_i),
        .src_edge_i  (src_edge_i),
        .src_level_i (src_level_i),
        .irq_o       (irq_o),
        .irq_level_o (irq_level_o),
        .irq_id_o    (irq_id_o),
        .irq_ack_i   (irq_ack_i)
    );

    // ---------------- reference model ----------------
    bit m_src  [N];
    bit m_pend [N];
    bit m_busy;
    int m_id;
    int m_lvl;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_src[i]  = 1'b0;
            m_pend[i] = 1'b0;
        end
        m_busy = 1'b0;
        m_id   = 0;
        m_lvl  = 0;
    endtask

    task automatic model_step();
        bit nxt [N];
        int best;
        for (int i = 0; i < N; i++) begin
            if (!src_ie_i[i])
                nxt[i] = 1'b0;
            else if (src_edge_i[i])
                nxt[i] = (src_i[i] && !m_src[i]) || (m_pend[i] && !(m_busy && irq_ack_i && m_id == i));
            else
                nxt[i] = src_i[i];
        end
        if (!m_busy) begin
            best = -1;
            for (int i = 0; i < N; i++)
                if (m_pend[i] && (best < 0 || src_level_i[i] >= src_level_i[best])) best = i;
            if (best >= 0) begin
                m_busy = 1'b1;
                m_id   = best;
                m_lvl  = int'(src_level_i[best]);
            end
        end else if (irq_ack_i || !(m_pend[m_id] && nxt[m_id])) begin
            m_busy = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            m_pend[i] = nxt[i];
            m_src[i]  = src_i[i];
        end
    endtask

    // ---------------- helpers ----------------
    function automatic logic [OW-1:0] want(int id, int lvl);
        logic [N-1:0] oh;
        oh = '0;
        if (id < 0) return '0;
        oh[id] = 1'b1;
        return {oh, 8'(lvl), IW'(id)};
    endfunction

    function automatic logic [OW-1:0] obs();
        return {irq_o, irq_level_o, irq_id_o};
    endfunction

    task automatic tick();
        @(posedge clk_i);
        if (rst_ni) model_step();
        else        model_reset();
        #1;
    endtask

    task automatic cfg(int id, bit edge_mode, logic [7:0] lvl);
        src_ie_i[id]    = 1'b1;
        src_edge_i[id]  = edge_mode;
        src_level_i[id] = lvl;
    endtask

    task automatic clear_all();
        src_i       = '0;
        src_ie_i    = '0;
        src_edge_i  = '0;
        src_level_i = '0;
        irq_ack_i   = 1'b0;
        repeat (3) tick();
    endtask

    task automatic ack_pulse();
        irq_ack_i = 1'b1;
        tick();
        irq_ack_i = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) tick();
        total++;
        if (obs() !== want(-1, 0)) begin
            bad++;
            $display("FAIL reset_outputs: got %h want %h", obs(), want(-1, 0));
        end
        rst_ni = 1'b1;
        repeat (2) tick();
        total++;
        if (obs() !== want(-1, 0)) begin
            bad++;
            $display("FAIL reset_idle_after_release: got %h want %h", obs(), want(-1, 0));
        end
        $display("test_reset done");
    endtask

    task automatic test_single_edge();
        cfg(5, 1'b1, 8'h10);
        src_i[5] = 1'b1;              // cycle 0
        tick();                       // cycle 1
        src_i[5] = 1'b0;
        total++;
        if (obs() !== want(-1, 0)) begin
            bad++;
            $display("FAIL single_edge_latency_c1: got %h want %h", obs(), want(-1, 0));
        end
        tick();                       // cycle 2
        total++;
        if (obs() !== want(5, 8'h10)) begin
            bad++;
            $display("FAIL single_edge_req_c2: got %h want %h", obs(), want(5, 8'h10));
        end
        tick();                       // cycle 3
        tick();                       // cycle 4
        total++;
        if (obs() !== want(5, 8'h10)) begin
            bad++;
            $display("FAIL single_edge_hold_c4: got %h want %h", obs(), want(5, 8'h10));
        end
        ack_pulse();                  // cycle 5
        total++;
        if (obs() !== want(-1, 0)) begin
            bad++;
            $display("FAIL single_edge_ack_drop: got %h want %h", obs(), want(-1, 0));
        end
        repeat (3) tick();
        total++;
        if (obs() !== want(-1, 0)) begin
            bad++;
            $display("FAIL single_edge_no_rereq: got %h want %h", obs(), want(-1, 0));
        end
        clear_all();
        $display("test_single_edge done");
    endtask

    task automatic test_priority();
        cfg(3, 1'b1, 8'h40);
        cfg(7, 1'b1, 8'h40);
        cfg(9, 1'b1, 8'h20);
        src_i[3] = 1'b1; src_i[7] = 1'b1; src_i[9] = 1'b1;
        tick();
        src_i = '0;
        tick();
        total++;
        if (obs() !== want(7, 8'h40)) begin
            bad++;
            $display("FAIL priority_first_id7: got %h want %h", obs(), want(7, 8'h40));
        end
        ack_pulse();
        tick();
        total++;
        if (obs() !== want(3, 8'h40)) begin
            bad++;
            $display("FAIL priority_second_id3: got %h want %h", obs(), want(3, 8'h40));
        end
        ack_pulse();
        tick();
        total++;
        if (obs() !== want(9, 8'h20)) begin
            bad++;
            $display("FAIL priority_third_id9: got %h want %h", obs(), want(9, 8'h20));
        end
        ack_pulse();
        tick();
        total++;
        if (obs() !== want(-1, 0)) begin
            bad++;
            $display("FAIL priority_drained: got %h want %h", obs(), want(-1, 0));
        end
        clear_all();
        $display("test_priority done");
    endtask

    task automatic test_no_preempt();
        cfg(9, 1'b1, 8'h20);
        src_i[9] = 1'b1;
        tick();
        src_i[9] = 1'b0;
        tick();
        cfg(12, 1'b1, 8'h80);
        src_i[12] = 1'b1;
        tick();
        src_i[12] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (obs() !== want(9, 8'h20)) begin
                bad++;
                $display("FAIL no_preempt_hold_%0d: got %h want %h", k, obs(), want(9, 8'h20));
            end
        end
        ack_pulse();                  // ack at n, now n+1
        total++;
        if (obs() !== want(-1, 0)) begin
            bad++;
            $display("FAIL no_preempt_gap: got %h want %h", obs(), want(-1, 0));
        end
        tick();                       // n+2
        total++;
        if (obs() !== want(12, 8'h80)) begin
            bad++;
            $display("FAIL no_preempt_next_id12: got %h want %h", obs(), want(12, 8'h80));
        end
        ack_pulse();
        clear_all();
        $display("test_no_preempt done");
    endtask

    task automatic test_level_withdraw();
        cfg(2, 1'b0, 8'h33);
        src_i[2] = 1'b1;
        repeat (2) tick();
        total++;
        if (obs() !== want(2, 8'h33)) begin
            bad++;
            $display("FAIL level_req: got %h want %h", obs(), want(2, 8'h33));
        end
        src_i[2] = 1'b0;              // cycle n
        tick();                       // n+1
        total++;
        if (obs() !== want(-1, 0)) begin
            bad++;
            $display("FAIL level_withdraw_src: got %h want %h", obs(), want(-1, 0));
        end
        tick();
        total++;
        if (obs() !== want(-1, 0)) begin
            bad++;
            $display("FAIL level_withdraw_stays_idle: got %h want %h", obs(), want(-1, 0));
        end
        src_i[2] = 1'b1;
        repeat (2) tick();
        total++;
        if (obs() !== want(2, 8'h33)) begin
            bad++;
            $display("FAIL level_rereq: got %h want %h", obs(), want(2, 8'h33));
        end
        src_ie_i[2] = 1'b0;
        tick();
        total++;
        if (obs() !== want(-1, 0)) begin
            bad++;
            $display("FAIL level_withdraw_ie: got %h want %h", obs(), want(-1, 0));
        end
        clear_all();
        $display("test_level_withdraw done");
    endtask

    task automatic test_ack_reedge();
        cfg(4, 1'b1, 8'h05);
        src_i[4] = 1'b1;
        tick();
        src_i[4] = 1'b0;
        tick();
        total++;
        if (obs() !== want(4, 8'h05)) begin
            bad++;
            $display("FAIL reedge_first_req: got %h want %h", obs(), want(4, 8'h05));
        end
        src_i[4]  = 1'b1;             // new edge in the ack cycle n
        irq_ack_i = 1'b1;
        tick();                       // n+1
        irq_ack_i = 1'b0;
        src_i[4]  = 1'b0;
        total++;
        if (obs() !== want(-1, 0)) begin
            bad++;
            $display("FAIL reedge_gap: got %h want %h", obs(), want(-1, 0));
        end
        tick();                       // n+2
        total++;
        if (obs() !== want(4, 8'h05)) begin
            bad++;
            $display("FAIL reedge_rereq: got %h want %h", obs(), want(4, 8'h05));
        end
        ack_pulse();
        repeat (2) tick();
        total++;
        if (obs() !== want(-1, 0)) begin
            bad++;
            $display("FAIL reedge_drained: got %h want %h", obs(), want(-1, 0));
        end
        clear_all();
        $display("test_ack_reedge done");
    endtask

    task automatic test_spurious_ack();
        irq_ack_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            total++;
            if (obs() !== want(-1, 0)) begin
                bad++;
                $display("FAIL spurious_ack_idle_%0d: got %h want %h", k, obs(), want(-1, 0));
            end
        end
        irq_ack_i = 1'b0;
        cfg(6, 1'b1, 8'h22);
        src_i[6] = 1'b1;
        tick();                       // pending set, FSM still IDLE
        src_i[6]  = 1'b0;
        irq_ack_i = 1'b1;             // ack while IDLE must not clear it
        tick();
        irq_ack_i = 1'b0;
        total++;
        if (obs() !== want(6, 8'h22)) begin
            bad++;
            $display("FAIL spurious_ack_kept_pending: got %h want %h", obs(), want(6, 8'h22));
        end
        ack_pulse();
        clear_all();
        $display("test_spurious_ack done");
    endtask

    task automatic test_reset_mid_req();
        cfg(8, 1'b1, 8'h77);
        src_i[8] = 1'b1;
        tick();
        src_i[8] = 1'b0;
        tick();
        total++;
        if (obs() !== want(8, 8'h77)) begin
            bad++;
            $display("FAIL reset_mid_req_setup: got %h want %h", obs(), want(8, 8'h77));
        end
        rst_ni = 1'b0;
        #2;
        total++;
        if (obs() !== want(-1, 0)) begin
            bad++;
            $display("FAIL reset_mid_req_async: got %h want %h", obs(), want(-1, 0));
        end
        tick();
        rst_ni = 1'b1;
        repeat (3) tick();
        total++;
        if (obs() !== want(-1, 0)) begin
            bad++;
            $display("FAIL reset_pending_lost: got %h want %h", obs(), want(-1, 0));
        end
        clear_all();
        $display("test_reset_mid_req done");
    endtask

    task automatic test_random();
        logic [7:0] lvl_tab [4];
        int id;
        lvl_tab[0] = 8'h00; lvl_tab[1] = 8'h10; lvl_tab[2] = 8'h40; lvl_tab[3] = 8'hFF;
        // Active ids include both ends of the id range.
        for (int j = 0; j < 64; j++) begin
            id = (j < 32) ? j : j + 192;
            src_ie_i[id]    = ($urandom_range(0, 3) != 0);
            src_edge_i[id]  = $urandom_range(0, 1);
            src_level_i[id] = lvl_tab[$urandom_range(0, 3)];
        end
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < 3; k++) begin
                id = $urandom_range(0, 63);
                id = (id < 32) ? id : id + 192;
                src_i[id] = ~src_i[id];
            end
            if ($urandom_range(0, 15) == 0) begin
                id = $urandom_range(0, 63);
                id = (id < 32) ? id : id + 192;
                src_ie_i[id]    = ~src_ie_i[id];
                src_level_i[id] = lvl_tab[$urandom_range(0, 3)];
            end
            irq_ack_i = m_busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
            tick();
            total++;
            if (obs() !== want(m_busy ? m_id : -1, m_busy ? m_lvl : 0)) begin
                bad++;
                $display("FAIL random_cycle_%0d: got %h want %h", c, obs(),
                         want(m_busy ? m_id : -1, m_busy ? m_lvl : 0));
            end
            total++;
            if (!$onehot0(irq_o)) begin
                bad++;
                $display("FAIL random_onehot0_%0d: got %h want at most one bit set", c, irq_o);
            end
        end
        clear_all();
        $display("test_random done");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single_edge();
        test_priority();
        test_no_preempt();
        test_level_withdraw();
        test_ack_reedge();
        test_spurious_ack();
        test_reset_mid_req();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
